// File: rtl/cla_arb_seq.sv
// cla_arb_seq: two-requester, round-robin arbitrated 64-bit add/subtract unit.
// One 32-bit carry-lookahead adder is time-shared: the low word is computed in
// the LO cycle, the high word in the HI cycle using the registered low carry.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req0/sub0/a0/b0       requester 0 request, op select (1 = A-B), operands
//   req1/sub1/a1/b1       requester 1 equivalents
//   gnt[1:0]              one-hot grant pulse (asserted in the LO cycle)
//   busy                  high in every state except IDLE
//   done                  one-cycle pulse qualifying result/c_out/ovf/done_id
//   done_id               requester that owns the current result
//   result[63:0]          sum or difference, modulo 2^64
//   c_out                 carry out of bit 63 (subtract: 1 = no borrow)
//   ovf                   signed two's-complement overflow

// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries
// chained through group generate/propagate terms.
module cla_arb_seq_cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  gg;
    logic [7:0]  pg;

    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        gg = '0;
        pg = '0;
        c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            // Every in-group carry is derived directly from the group carry-in.
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            gg[k]    = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pg[k]    = &p[4*k +: 4];
            c[4*k+4] = gg[k] | (pg[k] & c[4*k]);
        end
        sum  = p ^ c[31:0];
        cout = c[32];
    end
endmodule

module cla_arb_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        sub0,
    input  logic [63:0] a0,
    input  logic [63:0] b0,
    input  logic        req1,
    input  logic        sub1,
    input  logic [63:0] a1,
    input  logic [63:0] b1,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [63:0] result,
    output logic        c_out,
    output logic        ovf
);
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t      state_q,   state_d;
    logic [1:0]  gnt_q,     gnt_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        done_id_q, done_id_d;
    logic [63:0] result_q,  result_d;
    logic        c_out_q,   c_out_d;
    logic        ovf_q,     ovf_d;
    logic        carry_q,   carry_d;
    logic        last_q,    last_d;
    logic        id_q,      id_d;
    // Operand/datapath registers: written only on grant or in LO, no reset.
    logic [63:0] a_q,       a_d;
    logic [63:0] bx_q,      bx_d;
    logic        sub_q,     sub_d;
    logic [31:0] lo_q,      lo_d;

    logic        win1;
    logic        win_sub;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_cin;
    logic [31:0] add_sum;
    logic        add_cout;

    function automatic logic ovf_fn(input logic a_msb, input logic b_msb,
                                    input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Requester 1 wins when alone, or on a tie when requester 0 was granted last.
    assign win1    = req1 & (~req0 | ~last_q);
    assign win_sub = win1 ? sub1 : sub0;

    // Adder operand steering: high word in HI, low word otherwise.
    assign add_a   = (state_q == S_HI) ? a_q[63:32]  : a_q[31:0];
    assign add_b   = (state_q == S_HI) ? bx_q[63:32] : bx_q[31:0];
    assign add_cin = (state_q == S_HI) ? carry_q     : sub_q;

    cla_arb_seq_cla32 u_cla (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = 2'b00;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;
        carry_d   = carry_q;
        last_d    = last_q;
        id_d      = id_q;
        a_d       = a_q;
        bx_d      = bx_q;
        sub_d     = sub_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    a_d     = win1 ? a1 : a0;
                    // B is stored already inverted for subtract (A + ~B + 1).
                    bx_d    = win_sub ? ~(win1 ? b1 : b0) : (win1 ? b1 : b0);
                    sub_d   = win_sub;
                    id_d    = win1;
                    last_d  = win1;
                    gnt_d   = win1 ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                lo_d    = add_sum;
                carry_d = add_cout;
                state_d = S_HI;
            end
            S_HI: begin
                result_d  = {add_sum, lo_q};
                c_out_d   = add_cout;
                ovf_d     = ovf_fn(a_q[63], bx_q[63], add_sum[31]);
                done_id_d = id_q;
                done_d    = 1'b1;
                state_d   = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= '0;
            c_out_q   <= 1'b0;
            ovf_q     <= 1'b0;
            carry_q   <= 1'b0;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            c_out_q   <= c_out_d;
            ovf_q     <= ovf_d;
            carry_q   <= carry_d;
            last_q    <= last_d;
            id_q      <= id_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        bx_q  <= bx_d;
        sub_q <= sub_d;
        lo_q  <= lo_d;
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign result  = result_q;
    assign c_out   = c_out_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_cla_arb_seq.sv
// Directed testbench for cla_arb_seq with a result scoreboard.
module tb_cla_arb_seq;
    logic        clk;
    logic        rst_n;
    logic        req0, sub0, req1, sub1;
    logic [63:0] a0, b0, a1, b1;
    logic [1:0]  gnt;
    logic        busy, done, done_id, c_out, ovf;
    logic [63:0] result;

    typedef struct {
        logic        id;
        logic [63:0] res;
        logic        co;
        logic        ov;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    cla_arb_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .sub0    (sub0),
        .a0      (a0),
        .b0      (b0),
        .req1    (req1),
        .sub1    (sub1),
        .a1      (a1),
        .b1      (b1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .result  (result),
        .c_out   (c_out),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: full 65-bit add; overflow from carry into vs. out of bit 63.
    function automatic exp_t model(input logic id, input logic s,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [63:0] bb;
        logic [64:0] full;
        logic [63:0] low63;
        bb    = s ? ~b : b;
        full  = {1'b0, a} + {1'b0, bb} + {64'd0, s};
        low63 = {1'b0, a[62:0]} + {1'b0, bb[62:0]} + {63'd0, s};
        e.id  = id;
        e.res = full[63:0];
        e.co  = full[64];
        e.ov  = low63[63] ^ full[64];
        return e;
    endfunction

    // Scoreboard consumer: every done pulse pops and checks one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("result",  result,          e.res);
                chk("c_out",   64'(c_out),      64'(e.co));
                chk("ovf",     64'(ovf),        64'(e.ov));
                chk("done_id", 64'(done_id),    64'(e.id));
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, " gnt"},     64'(gnt),     64'd0);
        chk({tag, " busy"},    64'(busy),    64'd0);
        chk({tag, " done"},    64'(done),    64'd0);
        chk({tag, " done_id"}, 64'(done_id), 64'd0);
        chk({tag, " result"},  result,       64'd0);
        chk({tag, " c_out"},   64'(c_out),   64'd0);
        chk({tag, " ovf"},     64'(ovf),     64'd0);
    endtask

    // Called just after a negedge with the DUT idle.
    task automatic run_op(input logic id, input logic s, input logic [63:0] a,
                          input logic [63:0] b, input exp_t e, input string tag);
        int n;
        sb.push_back(e);
        if (id) begin req1 = 1'b1; sub1 = s; a1 = a; b1 = b; end
        else    begin req0 = 1'b1; sub0 = s; a0 = a; b0 = b; end
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
        chk({tag, " gnt"},     64'(gnt),  id ? 64'd2 : 64'd1);
        chk({tag, " gnt_lat"}, 64'(n),    64'd1);
        chk({tag, " busy"},    64'(busy), 64'd1);
        // Drop the request and scramble operands: the in-flight op must not care.
        req0 = 1'b0; req1 = 1'b0;
        a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom}; sub0 = ~s;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; sub1 = ~s;
        n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 20);
        chk({tag, " done_lat"}, 64'(n), 64'd2);
        @(negedge clk);
        chk({tag, " idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic        rs;
        int          n;

        rst_n = 1'b0;
        req0 = 1'b0; sub0 = 1'b0; a0 = '0; b0 = '0;
        req1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Both requesters held from reset: grants alternate 01,10,01,10 every 4 cycles.
        sb.push_back(model(1'b0, 1'b0, 64'd3,  64'd4));
        sb.push_back(model(1'b1, 1'b1, 64'd10, 64'd3));
        sb.push_back(model(1'b0, 1'b0, 64'd3,  64'd4));
        sb.push_back(model(1'b1, 1'b1, 64'd10, 64'd3));
        req0 = 1'b1; sub0 = 1'b0; a0 = 64'd3;  b0 = 64'd4;
        req1 = 1'b1; sub1 = 1'b1; a1 = 64'd10; b1 = 64'd3;
        for (int g = 0; g < 4; g++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
            chk("tie gnt", 64'(gnt), (g % 2 == 1) ? 64'd2 : 64'd1);
            chk("tie spacing", 64'(n), (g == 0) ? 64'd1 : 64'd4);
        end
        req0 = 1'b0; req1 = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
        chk("tie drain", 64'(sb.size()), 64'd0);
        @(negedge clk);

        run_op(1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1,
               '{1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0}, "add_carry32");
        run_op(1'b1, 1'b1, 64'd5, 64'd7,
               '{1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0}, "sub_neg");
        run_op(1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
               '{1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1}, "add_ovf");
        run_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               '{1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0}, "add_wrap");
        run_op(1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'd1,
               '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1}, "sub_ovf");
        for (int i = 0; i < 4; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rs = 1'($urandom_range(0, 1));
            run_op(1'(i % 2), rs, ra, rb, model(1'(i % 2), rs, ra, rb), "rand");
        end

        // Reset during HI aborts the operation with no done pulse.
        req0 = 1'b1; sub0 = 1'b0; a0 = 64'd100; b0 = 64'd200;
        n = 0;
        do begin @(negedge clk); n++; end while (gnt == 2'b00 && n < 20);
        chk("abort gnt", 64'(gnt), 64'd1);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort no_done", 64'(done), 64'd0);
        run_op(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
               model(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321),
               "post_reset");
        chk("final drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cla_arb_seq.md
CLA_ARB_SEQ -- requirements
Module: cla_arb_seq

Interface
REQ-001 Parameter: none; operand width is fixed at 64 bits, built from two 32-bit CLA passes.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 request; held high until gnt[0] is seen.
REQ-005 sub0  input  1  requester 0 operation: 0 = A+B, 1 = A-B.
REQ-006 a0, b0  input  64 each  requester 0 operands; valid while req0 is high.
REQ-007 req1, sub1, a1, b1  input  1/1/64/64  requester 1 equivalents of REQ-004..006.
REQ-008 gnt  output  2  one-hot grant pulse, one cycle; bit i means operands of requester i were captured.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse; result, c_out, ovf and done_id are valid in that cycle.
REQ-011 done_id  output  1  index of the requester that owns the current result.
REQ-012 result  output  64  sum or difference.
REQ-013 c_out  output  1  carry out of bit 63 (for subtract, 1 = no borrow).
REQ-014 ovf  output  1  signed two's-complement overflow of the 64-bit operation.

Function
REQ-015 The block SHALL contain exactly one 32-bit carry-lookahead adder instance (the team's 32-bit CLA) and SHALL time-share it across both words and both requesters.
REQ-016 States: IDLE, LO, HI, DONE; the encoding is free.
REQ-017 IDLE: if neither request is high, stay in IDLE. Otherwise, on the rising edge:
- capture the winner's a, b, sub and id
- go to LO
- gnt bit for the winner is high during the LO cycle only.
REQ-018 Arbitration SHALL be round-robin:
- a lone request wins
- on simultaneous requests, the requester not granted last wins
- the last-granted pointer resets to 1, so req0 wins the first tie.
REQ-019 Subtract SHALL be computed as A + ~B with the initial carry-in = 1; for add, carry-in = 0.
REQ-020 LO (one cycle): adder computes bits 31:0 with the initial carry-in; the low sum and carry-out are registered; go to HI.
REQ-021 HI (one cycle): adder computes bits 63:32 with the registered carry as C_in; result[63:32], c_out and ovf are registered; go to DONE.
- ovf = (A[63] == B'[63]) && (result[63] != A[63]), where B' is the post-inversion operand.
REQ-022 DONE (one cycle): done = 1; next state is IDLE unconditionally.
REQ-023 Latency: a request sampled in IDLE at edge k gives gnt in cycle k+1 and done in cycle k+3. Back-to-back throughput is one operation per 4 cycles.
REQ-024 Requests SHALL be ignored while busy; a request held through busy is arbitrated on the first IDLE cycle.
REQ-025 Operands and sub SHALL be sampled only at the grant edge; changes afterward SHALL NOT affect the in-flight result.
REQ-026 result, c_out, ovf and done_id SHALL hold their values from DONE until the next HI update; they are only qualified by done.
REQ-027 Wrap-around: carries out of bit 63 are reported on c_out only; result is modulo 2^64.
REQ-028 There are no illegal states reachable; any unencoded state SHALL transition to IDLE.

Reset
REQ-029 On rst_n low, asynchronously, the following SHALL be forced:
- state = IDLE
- gnt = 0, busy = 0, done = 0, done_id = 0
- result = 0, c_out = 0, ovf = 0
- internal carry = 0, round-robin pointer = 1.
REQ-030 Reset mid-operation SHALL abort the operation with no done pulse. After rst_n rises, the first edge with a request present is treated as an IDLE arbitration.

Verification
REQ-031 req0 only, add, a0=0x00000000_FFFFFFFF, b0=1 -> gnt=01 at k+1; done at k+3 with result=0x00000001_00000000, c_out=0, ovf=0, done_id=0.
REQ-032 req1 only, sub, a1=5, b1=7 -> result=0xFFFFFFFF_FFFFFFFE, c_out=0, ovf=0, done_id=1.
REQ-033 Both requests held continuously after reset -> grants alternate 01, 10, 01, 10, one every 4 cycles; done_id alternates 0, 1, 0, 1.
REQ-034 Add a0=0x7FFFFFFF_FFFFFFFF, b0=1 -> result=0x80000000_00000000, ovf=1, c_out=0. Add a0=b0=0xFFFFFFFF_FFFFFFFF -> result=0xFFFFFFFF_FFFFFFFE, c_out=1, ovf=0.
REQ-035 Change a0 the cycle after gnt -> result reflects the originally captured a0.
REQ-036 Assert rst_n low during HI -> outputs zero immediately, no done pulse; the next request completes normally with its correct result.
